w_seq: RTL
==========

Name: w_seq

Overview:
- Weight-stream sequencer for the GAN datapath (generator L2/L3, discriminator L2/L3).
- Drives the weight-set select into the weight memory and takes its four flattened weight buses.
- Serializes the weights, layer by layer and neuron by neuron, to a single MAC lane over a valid/ready handshake.
- Tags every word with layer, neuron and input indices and last flags, and signals completion.

Parameters:
- WIDTH, 32, weight word width (Q16.16 signed).
- N_INPUT, 2, generator input count.
- N_G_L2, 3, generator layer-2 neurons.
- N_G_L3, 9, generator layer-3 neurons.
- N_D_L2, 3, discriminator layer-2 neurons.
- N_D_L3, 1, discriminator layer-3 neurons.
- IDX_W, 4, index width; must hold max(neurons, inputs)-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a stream; ignored unless IDLE.
- abort  in  1  synchronous cancel; returns to IDLE.
- choice  in  1  weight set to use; sampled in LOAD.
- mode  in  2  00 full G2,G3,D2,D3; 01 generator only G2,G3; 10 discriminator only D2,D3; 11 treated as 00.
- wg2_i  in  N_INPUT*N_G_L2*WIDTH  generator L2 weights.
- wg3_i  in  N_G_L2*N_G_L3*WIDTH  generator L3 weights.
- wd2_i  in  N_G_L3*N_D_L2*WIDTH  discriminator L2 weights.
- wd3_i  in  N_D_L2*N_D_L3*WIDTH  discriminator L3 weights.
- choice_o  out  1  registered weight-set select to the memory.
- w_valid  out  1  w_data and tags are valid.
- w_ready  in  1  consumer accepts the word.
- w_data  out  WIDTH  current weight.
- w_layer  out  2  0=G2, 1=G3, 2=D2, 3=D3.
- w_nrn  out  IDX_W  neuron index.
- w_inp  out  IDX_W  input index.
- w_last_in  out  1  last input of the current neuron.
- w_last_layer  out  1  last word of the current layer.
- busy  out  1  high in LOAD and STREAM.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset: state=IDLE. choice_o, w_valid, busy and done are 0. Layer, neuron and input counters are 0. w_data is driven from the counters, so it equals wg2_i word 0.
- Weight addressing: a layer with Nin inputs holds word (n*Nin+i) at bits [(n*Nin+i)*WIDTH +: WIDTH]. Word 0 is the LSB. Nin per layer:
  - G2: N_INPUT
  - G3: N_G_L2
  - D2: N_G_L3
  - D3: N_D_L2
- Stream order: input index i fastest, then neuron n, then layer in the order set by mode.
- w_data is a combinational select of the four buses by the registered counters; no extra latency.
- States:
  - IDLE: on start, go to LOAD and latch mode. The start layer is 0, or 2 for mode 10.
  - LOAD: one cycle. choice_o <= choice so the weight-memory mux settles. Next state is STREAM.
  - STREAM: w_valid=1. On w_valid&&w_ready, advance i. Wrap i to 0 and advance n at Nin-1. Wrap n and move to the next layer at the layer's neuron count minus 1. After the final word of the final layer is accepted, go to DONE.
  - DONE: w_valid=0 and done=1 for exactly one cycle, then IDLE.
- Handshake: while w_valid&&!w_ready, w_data, the tags and the flags hold stable. w_ready is ignored outside STREAM.
- Flags:
  - w_last_in = (i==Nin-1).
  - w_last_layer = w_last_in && (n==neurons-1).
- Latency: start at cycle 0 gives LOAD at cycle 1 and first w_valid at cycle 2. With w_ready held high, one word is accepted per cycle.
- Word counts: full=63, generator only=33, discriminator only=30.
- choice_o holds its value after completion until the next LOAD.
- Boundaries:
  - start while busy or in DONE is ignored.
  - abort has priority over a same-cycle handshake. The next cycle shows IDLE, w_valid=0, no done, counters cleared, and choice_o unchanged.
  - abort in IDLE has no effect.
  - Asynchronous reset mid-stream clears everything immediately, including choice_o.
  - choice changes after LOAD have no effect on the current stream.

Test Plan:
- Full stream, choice=0, mode=00, w_ready=1, start at cycle 0:
  - Words 0 and 1 are 0xFFFF136B and 0x0003B16C.
  - Word 6 is 0x00A48E44 with w_layer=1.
  - Word 62 is 0x01537752 with w_last_layer=1.
  - done pulses at cycle 65; 63 handshakes total.
- choice=1, mode=01:
  - choice_o=1 from cycle 2.
  - 33 words, first 0x00031B23, last 0x007A5F49 (w_layer=1, n=8, i=2).
  - done follows, and choice_o stays 1 after done.
- choice=0, mode=10:
  - 30 words; first 0xFFD27D37 with w_layer=2, n=0, i=0.
  - Word 8 has w_last_in=1 (i=8).
  - Word 27 is 0xFD5761CC with w_layer=3.
- Backpressure: w_ready=0 for 3 cycles while word 4 (0x0011018B, n=2, i=0) is presented.
  - Data and tags stay stable throughout.
  - The stream resumes with word 5 = 0x0003A141; total count is unchanged.
- Control boundaries:
  - abort at word 20 gives w_valid=0 and busy=0 next cycle, with no done.
  - A start pulse during STREAM is ignored.
  - rst_n low at word 10 clears all outputs asynchronously, choice_o included.
  - A new start afterwards streams correctly from word 0.

Source files
------------

// File: rtl/w_seq.sv
// Weight-stream sequencer: walks the generator/discriminator weight buses layer by layer
// and neuron by neuron, presenting one tagged weight word per valid/ready handshake.
module w_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_INPUT = 2,
    parameter int unsigned N_G_L2  = 3,
    parameter int unsigned N_G_L3  = 9,
    parameter int unsigned N_D_L2  = 3,
    parameter int unsigned N_D_L3  = 1,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             choice,
    input  logic [1:0]                       mode,
    input  logic [N_INPUT*N_G_L2*WIDTH-1:0]  wg2_i,
    input  logic [N_G_L2*N_G_L3*WIDTH-1:0]   wg3_i,
    input  logic [N_G_L3*N_D_L2*WIDTH-1:0]   wd2_i,
    input  logic [N_D_L2*N_D_L3*WIDTH-1:0]   wd3_i,
    output logic                             choice_o,
    output logic                             w_valid,
    input  logic                             w_ready,
    output logic [WIDTH-1:0]                 w_data,
    output logic [1:0]                       w_layer,
    output logic [IDX_W-1:0]                 w_nrn,
    output logic [IDX_W-1:0]                 w_inp,
    output logic                             w_last_in,
    output logic                             w_last_layer,
    output logic                             busy,
    output logic                             done
);

    typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

    localparam logic [1:0] LyrG2 = 2'd0;
    localparam logic [1:0] LyrG3 = 2'd1;
    localparam logic [1:0] LyrD2 = 2'd2;
    localparam logic [1:0] LyrD3 = 2'd3;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       layer_q, layer_d;
    logic [IDX_W-1:0] nrn_q, nrn_d;
    logic [IDX_W-1:0] inp_q, inp_d;
    logic             choice_q, choice_d;

    logic             last_in;
    logic             last_nrn;
    logic             final_layer;
    logic [31:0]      word_idx;
    logic [31:0]      shamt;

    // Fan-in of each layer: the previous layer's neuron count.
    function automatic int unsigned nin_of(input logic [1:0] lyr);
        int unsigned n;
        n = N_INPUT;
        unique case (lyr)
            LyrG2: n = N_INPUT;
            LyrG3: n = N_G_L2;
            LyrD2: n = N_G_L3;
            LyrD3: n = N_D_L2;
            default: n = N_INPUT;
        endcase
        return n;
    endfunction

    function automatic int unsigned nn_of(input logic [1:0] lyr);
        int unsigned n;
        n = N_G_L2;
        unique case (lyr)
            LyrG2: n = N_G_L2;
            LyrG3: n = N_G_L3;
            LyrD2: n = N_D_L2;
            LyrD3: n = N_D_L3;
            default: n = N_G_L2;
        endcase
        return n;
    endfunction

    assign last_in     = (32'(inp_q) == nin_of(layer_q) - 1);
    assign last_nrn    = (32'(nrn_q) == nn_of(layer_q) - 1);
    // Generator-only streams end at G3; every other mode (including 11) ends at D3.
    assign final_layer = (mode_q == 2'b01) ? (layer_q == LyrG3) : (layer_q == LyrD3);
    assign word_idx    = 32'(nrn_q) * nin_of(layer_q) + 32'(inp_q);
    assign shamt       = word_idx * WIDTH;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mode_q   <= 2'b00;
            layer_q  <= LyrG2;
            nrn_q    <= '0;
            inp_q    <= '0;
            choice_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            layer_q  <= layer_d;
            nrn_q    <= nrn_d;
            inp_q    <= inp_d;
            choice_q <= choice_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        layer_d  = layer_q;
        nrn_d    = nrn_q;
        inp_d    = inp_q;
        choice_d = choice_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    mode_d  = mode;
                    layer_d = (mode == 2'b10) ? LyrD2 : LyrG2;
                    nrn_d   = '0;
                    inp_d   = '0;
                end
            end
            StLoad: begin
                choice_d = choice;
                state_d  = StStream;
            end
            StStream: begin
                if (w_ready) begin
                    if (!last_in) begin
                        inp_d = inp_q + IDX_W'(1);
                    end else begin
                        inp_d = '0;
                        if (!last_nrn) begin
                            nrn_d = nrn_q + IDX_W'(1);
                        end else begin
                            nrn_d = '0;
                            if (final_layer) begin
                                state_d = StDone;
                                layer_d = LyrG2;
                            end else begin
                                layer_d = layer_q + 2'd1;
                            end
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort wins over any same-cycle handshake; the memory select is left untouched.
        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            layer_d  = LyrG2;
            nrn_d    = '0;
            inp_d    = '0;
            choice_d = choice_q;
        end
    end

    // Outputs
    always_comb begin
        w_valid      = (state_q == StStream);
        busy         = (state_q == StLoad) || (state_q == StStream);
        done         = (state_q == StDone);
        choice_o     = choice_q;
        w_layer      = layer_q;
        w_nrn        = nrn_q;
        w_inp        = inp_q;
        w_last_in    = last_in;
        w_last_layer = last_in && last_nrn;
        w_data       = '0;
        unique case (layer_q)
            LyrG2: w_data = WIDTH'(wg2_i >> shamt);
            LyrG3: w_data = WIDTH'(wg3_i >> shamt);
            LyrD2: w_data = WIDTH'(wd2_i >> shamt);
            LyrD3: w_data = WIDTH'(wd3_i >> shamt);
            default: w_data = '0;
        endcase
    end

endmodule
